// File: rtl/soda_customer_driver.sv
// Customer-side initiator for the soda vending machine: inserts a one- or two-coin
// payment, steps the machine with next pulses until soda appears, and tallies change.
module soda_customer_driver #(
   parameter int PULSE_HIGH = 4,
   parameter int PULSE_LOW  = 4,
   parameter int MAX_PULSES = 8
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [1:0] coin_a,
   input  logic [1:0] coin_b,
   input  logic       two_coins,
   input  logic       check_coin_in,
   input  logic       soda,
   input  logic [1:0] coin_out,
   output logic       next,
   output logic [1:0] coin_in,
   output logic       busy,
   output logic       done,
   output logic [3:0] change_total,
   output logic       soda_got,
   output logic       underpaid,
   output logic       timeout_err
);

   localparam int TMAX = (PULSE_HIGH > PULSE_LOW) ? PULSE_HIGH : PULSE_LOW;
   localparam int TW   = $clog2(TMAX + 1);
   localparam int PW   = $clog2(MAX_PULSES + 1);
   localparam logic [TW-1:0] HI_LAST   = TW'(PULSE_HIGH - 1);
   localparam logic [TW-1:0] LO_LAST   = TW'(PULSE_LOW - 1);
   localparam logic [PW-1:0] PULSE_MAX = PW'(MAX_PULSES);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_HI, S_LO, S_EVAL, S_FIN, S_ERR
   } state_t;

   state_t          r_state;
   logic [1:0]      r_coin_b;
   logic            r_coin_left;
   logic            r_final;
   logic [PW-1:0]   r_pulses;
   logic [TW-1:0]   r_timer;

   logic [1:0]      w_change_add;
   logic [4:0]      w_change_sum;
   logic [3:0]      w_change_sat;
   logic            w_plan_ends;
   logic            w_bad_plan;

   always_comb begin
      w_change_add = 2'd0;
      if (coin_out == 2'b10)
         w_change_add = 2'd2;
      else if (coin_out == 2'b01)
         w_change_add = 2'd1;
   end

   assign w_change_sum = {1'b0, change_total} + {3'b000, w_change_add};
   assign w_change_sat = w_change_sum[4] ? 4'hF : w_change_sum[3:0];
   // The only EVAL outcome that needs no further pulse is "machine wants a coin, plan is empty".
   assign w_plan_ends  = !soda && (w_change_add == 2'd0) && check_coin_in && !r_coin_left;
   assign w_bad_plan   = (coin_a == 2'b00) || (two_coins && (coin_b == 2'b00));

   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state      <= S_IDLE;
         r_coin_b     <= 2'b00;
         r_coin_left  <= 1'b0;
         r_final      <= 1'b0;
         r_pulses     <= '0;
         r_timer      <= '0;
         next         <= 1'b0;
         coin_in      <= 2'b00;
         busy         <= 1'b0;
         done         <= 1'b0;
         change_total <= 4'd0;
         soda_got     <= 1'b0;
         underpaid    <= 1'b0;
         timeout_err  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_coin_b     <= coin_b;
                  r_coin_left  <= two_coins;
                  r_final      <= 1'b0;
                  r_pulses     <= '0;
                  change_total <= 4'd0;
                  soda_got     <= 1'b0;
                  underpaid    <= 1'b0;
                  timeout_err  <= 1'b0;
                  busy         <= 1'b1;
                  if (w_bad_plan) begin
                     r_state <= S_ERR;
                  end else begin
                     coin_in <= coin_a;
                     r_state <= S_SETUP;
                  end
               end
            end
            S_SETUP: begin
               r_pulses <= r_pulses + PW'(1);
               r_timer  <= '0;
               next     <= 1'b1;
               r_state  <= S_HI;
            end
            S_HI: begin
               if (r_timer == HI_LAST) begin
                  r_timer <= '0;
                  next    <= 1'b0;
                  r_state <= S_LO;
               end else begin
                  r_timer <= r_timer + TW'(1);
               end
            end
            S_LO: begin
               if (r_timer == LO_LAST)
                  r_state <= r_final ? S_FIN : S_EVAL;
               else
                  r_timer <= r_timer + TW'(1);
            end
            S_EVAL: begin
               if (!w_plan_ends && (r_pulses == PULSE_MAX)) begin
                  r_state <= S_ERR;
               end else if (soda) begin
                  soda_got <= 1'b1;
                  r_final  <= 1'b1;
                  coin_in  <= 2'b00;
                  r_state  <= S_SETUP;
               end else if (w_change_add != 2'd0) begin
                  change_total <= w_change_sat;
                  coin_in      <= 2'b00;
                  r_state      <= S_SETUP;
               end else if (check_coin_in) begin
                  if (r_coin_left) begin
                     r_coin_left <= 1'b0;
                     coin_in     <= r_coin_b;
                     r_state     <= S_SETUP;
                  end else begin
                     underpaid <= 1'b1;
                     r_state   <= S_FIN;
                  end
               end else begin
                  coin_in <= 2'b00;
                  r_state <= S_SETUP;
               end
            end
            S_FIN: begin
               done    <= 1'b1;
               busy    <= 1'b0;
               coin_in <= 2'b00;
               r_state <= S_IDLE;
            end
            S_ERR: begin
               timeout_err <= 1'b1;
               done        <= 1'b1;
               busy        <= 1'b0;
               coin_in     <= 2'b00;
               r_state     <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_soda_customer_driver.sv
// Bench for soda_customer_driver: two driver instances, each talking to a behavioural
// vending machine (price 2), plus a transaction-level reference model.
module tb_soda_customer_driver;

   localparam int PH = 4;
   localparam int PL = 4;

   localparam logic [2:0] M_IDLE0 = 3'd0;
   localparam logic [2:0] M_C1    = 3'd1;
   localparam logic [2:0] M_R4    = 3'd2;
   localparam logic [2:0] M_R3    = 3'd3;
   localparam logic [2:0] M_R1    = 3'd4;
   localparam logic [2:0] M_SODA  = 3'd5;

   logic clk = 1'b0;
   logic reset, start, start_2, two_coins;
   logic [1:0] coin_a, coin_b;

   logic check_coin_in, soda, next, busy, done, soda_got, underpaid, timeout_err;
   logic [1:0] coin_out, coin_in;
   logic [3:0] change_total;
   logic check_coin_in_2, soda_2, next_2, busy_2, done_2, soda_got_2, underpaid_2, timeout_err_2;
   logic [1:0] coin_out_2, coin_in_2;
   logic [3:0] change_total_2;

   logic [2:0] m_st, m_st_2;
   logic m_n1, m_n2, m_n1_2, m_n2_2;

   int n_checks = 0;
   int n_errors = 0;
   int pulse_cnt = 0;
   int hi_run = 0;
   int low_run = 100;
   logic prev_next = 1'b0;
   logic [1:0] prev_coin = 2'b00;
   bit mon_en = 1'b0;
   int res_cycles, res_pulses;
   bit res_seen;
   int model_credit = 0;

   always #5 clk = ~clk;

   soda_customer_driver #(.PULSE_HIGH(PH), .PULSE_LOW(PL), .MAX_PULSES(8)) u_dut (
      .clk(clk), .reset(reset), .start(start), .coin_a(coin_a), .coin_b(coin_b),
      .two_coins(two_coins), .check_coin_in(check_coin_in), .soda(soda), .coin_out(coin_out),
      .next(next), .coin_in(coin_in), .busy(busy), .done(done), .change_total(change_total),
      .soda_got(soda_got), .underpaid(underpaid), .timeout_err(timeout_err));

   soda_customer_driver #(.PULSE_HIGH(PH), .PULSE_LOW(PL), .MAX_PULSES(2)) u_dut_2 (
      .clk(clk), .reset(reset), .start(start_2), .coin_a(coin_a), .coin_b(coin_b),
      .two_coins(two_coins), .check_coin_in(check_coin_in_2), .soda(soda_2), .coin_out(coin_out_2),
      .next(next_2), .coin_in(coin_in_2), .busy(busy_2), .done(done_2), .change_total(change_total_2),
      .soda_got(soda_got_2), .underpaid(underpaid_2), .timeout_err(timeout_err_2));

   // Vending machine: credit 0/1 waits for coins, overpayment is paid back before soda.
   function automatic logic [2:0] m_step(input logic [2:0] s, input logic [1:0] c);
      logic [2:0] n;
      n = s;
      case (s)
         M_IDLE0: n = (c == 2'b01) ? M_C1 : (c == 2'b10) ? M_SODA : (c == 2'b11) ? M_R3 : M_IDLE0;
         M_C1:    n = (c == 2'b01) ? M_SODA : (c == 2'b10) ? M_R1 : (c == 2'b11) ? M_R4 : M_C1;
         M_R4:    n = M_R3;
         M_R3:    n = M_R1;
         M_R1:    n = M_SODA;
         M_SODA:  n = M_IDLE0;
         default: n = M_IDLE0;
      endcase
      return n;
   endfunction

   always @(posedge clk) begin
      if (!reset) begin
         m_st <= M_IDLE0; m_n1 <= 1'b0; m_n2 <= 1'b0;
         m_st_2 <= M_IDLE0; m_n1_2 <= 1'b0; m_n2_2 <= 1'b0;
      end else begin
         m_n1 <= next; m_n2 <= m_n1;
         if (m_n1 && !m_n2) m_st <= m_step(m_st, coin_in);
         m_n1_2 <= next_2; m_n2_2 <= m_n1_2;
         if (m_n1_2 && !m_n2_2) m_st_2 <= m_step(m_st_2, coin_in_2);
      end
   end

   assign check_coin_in   = (m_st == M_IDLE0) || (m_st == M_C1);
   assign soda            = (m_st == M_SODA);
   assign coin_out        = (m_st == M_R3) ? 2'b10 : ((m_st == M_R4) || (m_st == M_R1)) ? 2'b01 : 2'b00;
   assign check_coin_in_2 = (m_st_2 == M_IDLE0) || (m_st_2 == M_C1);
   assign soda_2          = (m_st_2 == M_SODA);
   assign coin_out_2      = (m_st_2 == M_R3) ? 2'b10 : ((m_st_2 == M_R4) || (m_st_2 == M_R1)) ? 2'b01 : 2'b00;

   // Pulse-shape monitor on the first instance.
   always @(negedge clk) begin
      if (!mon_en) begin
         hi_run = 0; low_run = 100; prev_next = 1'b0; prev_coin = coin_in;
      end else begin
         if (next && !prev_next) pulse_cnt++;
         if (next) begin
            hi_run++; low_run = 0;
         end else if (prev_next) begin
            n_checks++;
            if (hi_run != PH) begin n_errors++; $display("FAIL next_high_len: got %0d cycles, want %0d", hi_run, PH); end
            hi_run = 0;
         end
         if (coin_in !== prev_coin) begin
            n_checks++;
            if (next || low_run < PL + 1) begin
               n_errors++;
               $display("FAIL coin_in_stable: coin_in %b->%b with next=%b after %0d low cycles, want >= %0d", prev_coin, coin_in, next, low_run, PL + 1);
            end
         end
         if (!next) low_run++;
         prev_next = next; prev_coin = coin_in;
      end
   end

   function automatic int coin_val(input logic [1:0] c);
      return (c == 2'b01) ? 1 : (c == 2'b10) ? 2 : (c == 2'b11) ? 5 : 0;
   endfunction

   // Transaction-level view: machine credit, list of change coins owed, and pending coins.
   task automatic model(input logic [1:0] ca, input logic [1:0] cb, input logic two, input int maxp,
                        output int chg, output bit sg, output bit up, output bit te, output int np);
      int val[$];
      int owed[$];
      bit sd, chk, need, ins;
      int total;
      chg = 0; sg = 0; up = 0; te = 0; np = 0; sd = 0; ins = 1;
      if (ca == 2'b00 || (two && cb == 2'b00)) begin te = 1; return; end
      val.push_back(coin_val(ca));
      if (two) val.push_back(coin_val(cb));
      for (int k = 0; k < 32; k++) begin
         np++;
         if (ins) begin
            total = model_credit + val.pop_front();
            if (total < 2) model_credit = total;
            else begin
               model_credit = 0;
               if (total == 2) sd = 1;
               else if (total == 3) owed = '{1};
               else if (total == 5) owed = '{2, 1};
               else owed = '{1, 2, 1};
            end
         end else if (owed.size() > 0) begin
            void'(owed.pop_front());
            if (owed.size() == 0) sd = 1;
         end
         chk  = !sd && owed.size() == 0;
         need = !(chk && val.size() == 0);
         if (need && np == maxp) begin te = 1; break; end
         if (sd) begin sg = 1; np++; break; end
         if (owed.size() > 0) begin
            chg = (chg + owed[0] > 15) ? 15 : chg + owed[0]; ins = 0;
         end else if (chk) begin
            if (val.size() > 0) ins = 1;
            else begin up = 1; break; end
         end else ins = 0;
      end
   endtask

   task automatic run_txn(input logic [1:0] ca, input logic [1:0] cb, input logic two);
      int p0;
      @(negedge clk);
      coin_a = ca; coin_b = cb; two_coins = two; start = 1'b1; p0 = pulse_cnt;
      @(negedge clk);
      start = 1'b0; res_cycles = 1;
      while (!done && res_cycles < 600) begin @(negedge clk); res_cycles++; end
      res_seen = done; res_pulses = pulse_cnt - p0;
   endtask

   task automatic test_reset;
      reset = 1'b0; start = 1'b0; start_2 = 1'b0; coin_a = 2'b00; coin_b = 2'b00; two_coins = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if ({next, coin_in, busy, done} !== 5'b0) begin n_errors++; $display("FAIL reset_ctrl: next/coin_in/busy/done=%b, want 00000", {next, coin_in, busy, done}); end
      n_checks++; if ({change_total, soda_got, underpaid, timeout_err} !== 7'b0) begin n_errors++; $display("FAIL reset_results: got %b, want 0000000", {change_total, soda_got, underpaid, timeout_err}); end
      reset = 1'b1;
      @(negedge clk);
      mon_en = 1'b1;
   endtask

   task automatic test_single_coin;
      run_txn(2'b10, 2'b00, 1'b0);
      n_checks++; if (res_seen !== 1'b1) begin n_errors++; $display("FAIL single_done: got %0b, want 1", res_seen); end
      n_checks++; if ({soda_got, underpaid, timeout_err, change_total} !== 7'b1000000) begin n_errors++; $display("FAIL single_result: soda/under/terr/chg=%b, want 1000000", {soda_got, underpaid, timeout_err, change_total}); end
      n_checks++; if (res_pulses != 2) begin n_errors++; $display("FAIL single_pulses: got %0d, want 2", res_pulses); end
      n_checks++; if (check_coin_in !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL single_idle: check_coin_in=%b busy=%b, want 1 0", check_coin_in, busy); end
   endtask

   task automatic test_change;
      run_txn(2'b11, 2'b00, 1'b0);
      n_checks++; if (change_total !== 4'd3 || soda_got !== 1'b1) begin n_errors++; $display("FAIL change_result: chg=%0d soda=%b, want 3 1", change_total, soda_got); end
      n_checks++; if (res_pulses != 4) begin n_errors++; $display("FAIL change_pulses: got %0d, want 4", res_pulses); end
   endtask

   task automatic test_two_coins;
      run_txn(2'b01, 2'b11, 1'b1);
      n_checks++; if (change_total !== 4'd4 || soda_got !== 1'b1) begin n_errors++; $display("FAIL two_result: chg=%0d soda=%b, want 4 1", change_total, soda_got); end
      n_checks++; if (res_pulses != 6) begin n_errors++; $display("FAIL two_pulses: got %0d, want 6", res_pulses); end
   endtask

   task automatic test_underpaid;
      run_txn(2'b01, 2'b00, 1'b0);
      n_checks++; if (res_seen !== 1'b1 || underpaid !== 1'b1 || soda_got !== 1'b0) begin n_errors++; $display("FAIL underpaid_result: done=%b under=%b soda=%b, want 1 1 0", res_seen, underpaid, soda_got); end
      n_checks++; if (res_pulses != 1) begin n_errors++; $display("FAIL underpaid_pulses: got %0d, want 1", res_pulses); end
      model_credit = 1;
   endtask

   task automatic test_invalid;
      run_txn(2'b00, 2'b10, 1'b0);
      n_checks++; if (res_seen !== 1'b1 || res_cycles > 3) begin n_errors++; $display("FAIL invalid_latency: done=%b after %0d cycles, want done within 3", res_seen, res_cycles); end
      n_checks++; if (timeout_err !== 1'b1 || underpaid !== 1'b0 || res_pulses != 0) begin n_errors++; $display("FAIL invalid_result: terr=%b under=%b pulses=%0d, want 1 0 0", timeout_err, underpaid, res_pulses); end
   endtask

   task automatic test_timeout;
      int cyc;
      @(negedge clk);
      coin_a = 2'b11; coin_b = 2'b00; two_coins = 1'b0; start_2 = 1'b1;
      @(negedge clk);
      start_2 = 1'b0; cyc = 1;
      while (!done_2 && cyc < 600) begin @(negedge clk); cyc++; end
      n_checks++; if (done_2 !== 1'b1) begin n_errors++; $display("FAIL timeout_done: got %b, want 1", done_2); end
      n_checks++; if (timeout_err_2 !== 1'b1 || soda_got_2 !== 1'b0 || change_total_2 !== 4'd2 || busy_2 !== 1'b0) begin
         n_errors++; $display("FAIL timeout_result: terr=%b soda=%b chg=%0d busy=%b, want 1 0 2 0", timeout_err_2, soda_got_2, change_total_2, busy_2);
      end
   endtask

   task automatic test_reset_mid_pulse;
      int cyc;
      mon_en = 1'b0;
      @(negedge clk);
      coin_a = 2'b11; two_coins = 1'b0; start = 1'b1;
      @(negedge clk);
      start = 1'b0; cyc = 0;
      while (!next && cyc < 50) begin @(negedge clk); cyc++; end
      n_checks++; if (next !== 1'b1) begin n_errors++; $display("FAIL midreset_pulse_seen: next=%b, want 1", next); end
      @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      n_checks++; if (next !== 1'b0 || busy !== 1'b0 || coin_in !== 2'b00) begin n_errors++; $display("FAIL midreset_outputs: next=%b busy=%b coin_in=%b, want 0 0 00", next, busy, coin_in); end
      reset = 1'b1; model_credit = 0;
      @(negedge clk);
      mon_en = 1'b1;
      run_txn(2'b10, 2'b00, 1'b0);
      n_checks++; if (res_seen !== 1'b1 || soda_got !== 1'b1 || res_pulses != 2) begin n_errors++; $display("FAIL midreset_recover: done=%b soda=%b pulses=%0d, want 1 1 2", res_seen, soda_got, res_pulses); end
   endtask

   task automatic test_random;
      logic [1:0] ca, cb;
      logic two;
      int e_chg, e_np;
      bit e_sg, e_up, e_te;
      for (int i = 0; i < 24; i++) begin
         ca = 2'($urandom_range(0, 3)); cb = 2'($urandom_range(0, 3)); two = 1'($urandom_range(0, 1));
         model(ca, cb, two, 8, e_chg, e_sg, e_up, e_te, e_np);
         run_txn(ca, cb, two);
         n_checks++; if (res_seen !== 1'b1 || busy !== 1'b0) begin n_errors++; $display("FAIL rand_done[%0d]: done=%b busy=%b, want 1 0", i, res_seen, busy); end
         n_checks++;
         if ({soda_got, underpaid, timeout_err} !== {e_sg, e_up, e_te} || change_total !== e_chg[3:0] || res_pulses != e_np) begin
            n_errors++;
            $display("FAIL rand_result[%0d] a=%b b=%b two=%b: soda/under/terr=%b chg=%0d pulses=%0d, want %b chg=%0d pulses=%0d",
                     i, ca, cb, two, {soda_got, underpaid, timeout_err}, change_total, res_pulses, {e_sg, e_up, e_te}, e_chg, e_np);
         end
      end
   endtask

   initial begin
      test_reset();
      test_single_coin();
      test_change();
      test_two_coins();
      test_underpaid();
      test_invalid();
      test_timeout();
      test_reset_mid_pulse();
      test_random();
      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/soda_customer_driver.md
Name: soda_customer_driver

Overview:
- Customer-side initiator for the soda vending FSM. It drives the machine's next/coin_in inputs and observes its soda/coin_out/check_coin_in outputs.
- On a start request it inserts a programmed payment of one or two coins, then keeps stepping the machine with next pulses until the soda is delivered. It tallies the change returned along the way.
- It sits between a test/user front end and the vending machine, which runs on the same clock.

Parameters:
- PULSE_HIGH, 4, cycles next is held high per pulse; must be at least 2.
- PULSE_LOW, 4, cycles next is held low after each pulse before evaluating; must be at least 2.
- MAX_PULSES, 8, maximum next pulses per transaction before a timeout.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- start  input  1  request a purchase; sampled only in IDLE.
- coin_a  input  2  first coin code: 01 = 1, 10 = 2, 11 = 5; 00 is invalid.
- coin_b  input  2  second coin code; used only when two_coins = 1.
- two_coins  input  1  1 = the plan is coin_a then coin_b.
- check_coin_in  input  1  from the machine; 1 = machine accepts a coin.
- soda  input  1  from the machine; 1 = soda delivered.
- coin_out  input  2  from the machine: 10 = 2 returned, 01 = 1 returned, 00 = none.
- next  output  1  step pulse to the machine; registered.
- coin_in  output  2  coin presented to the machine; registered.
- busy  output  1  transaction in progress.
- done  output  1  one-cycle pulse when a transaction ends.
- change_total  output  4  sum of returned coin values.
- soda_got  output  1  soda was observed in this transaction.
- underpaid  output  1  plan exhausted before soda; machine keeps its credit.
- timeout_err  output  1  MAX_PULSES exceeded, or an invalid coin code.

Behaviour:
- Reset (reset = 0 at a clock edge) takes effect the next cycle and applies even mid-pulse:
  - state goes to IDLE;
  - next = 0, coin_in = 00, busy = 0, done = 0;
  - change_total = 0, soda_got = 0, underpaid = 0, timeout_err = 0.
  - The pulse counter and coin index are cleared.
- States: IDLE, SETUP, HI, LO, EVAL, FIN, ERR.
- IDLE, on start = 1:
  - Latch coin_a, coin_b and two_coins.
  - Clear change_total, soda_got, underpaid, timeout_err and the pulse counter.
  - Set busy = 1.
  - If the latched coin_a = 00, or two_coins = 1 and coin_b = 00, go to ERR.
  - Otherwise load coin_in = coin_a and go to SETUP.
  - start is ignored outside IDLE.
- Pulse sequence:
  - SETUP lasts 1 cycle with next = 0 and coin_in already driven.
  - HI lasts PULSE_HIGH cycles with next = 1.
  - LO lasts PULSE_LOW cycles with next = 0.
  - coin_in is held constant from SETUP through the end of LO.
  - Each entry to SETUP increments the pulse counter.
- EVAL lasts 1 cycle and samples soda, coin_out and check_coin_in. Decisions, in priority order:
  1. Pulse counter = MAX_PULSES and another pulse is needed: go to ERR.
  2. soda = 1: set soda_got = 1, then issue one final pulse with coin_in = 00 to return the machine to idle. After that pulse, go to FIN.
  3. coin_out = 10: add 2 to change_total, then issue a pulse with coin_in = 00.
  4. coin_out = 01: add 1 to change_total, then issue a pulse with coin_in = 00.
  5. check_coin_in = 1 and a plan coin remains: issue a pulse with coin_in = next plan coin.
  6. check_coin_in = 1 and no coin remains: set underpaid = 1 and go to FIN.
  7. Otherwise: issue an advance pulse with coin_in = 00.
- Each coin_out value is added exactly once per EVAL. change_total saturates at 15.
- FIN: done = 1 for one cycle, busy = 0, coin_in = 00, then IDLE.
- ERR: set timeout_err = 1, then behave as FIN.
- Result outputs (change_total, soda_got, underpaid, timeout_err) hold until the next accepted start or reset.
- Machine timing:
  - The machine edge-detects next through 2 flops and updates its state 2 cycles after next rises.
  - The required parameter minimums guarantee that coin_in is stable at the machine's sample point and that its outputs have settled by EVAL.

Test Plan:
- coin_a = 10, two_coins = 0: 2 pulses (coin, final). Expect done; soda_got = 1, change_total = 0, underpaid = 0; machine back in its idle state with check_coin_in = 1.
- coin_a = 11: pulses coin, change 2, change 1, final. Expect change_total = 3, soda_got = 1; 4 pulses total.
- coin_a = 01, coin_b = 11, two_coins = 1: change steps 1 + 2 + 1. Expect change_total = 4, soda_got = 1; 6 pulses.
- coin_a = 01, two_coins = 0: one pulse, then EVAL sees check_coin_in = 1 with no coins left. Expect underpaid = 1, soda_got = 0, done pulse.
- coin_a = 00: ERR without any next pulse. Expect timeout_err = 1 and done within 3 cycles.
- Separately, MAX_PULSES = 2 with coin_a = 11: expect timeout_err = 1.
- Reset asserted during HI: expect next = 0 and busy = 0 on the next cycle. A new start then completes normally.
- With PULSE_HIGH = 4 and PULSE_LOW = 4: check next is high for exactly 4 cycles and coin_in changes only in EVAL/IDLE.
